match_controller: RTL and testbench

- Parametrised match sequencer for the pong-style game; replaces the fixed two-player start/score logic.
- Supports N players, a configurable win score, and frame-counted serve and point hold-off delays.
- Consumes scoring events from the game physics and the VGA vsync.
- Drives ball enable, serving player, packed scores (to seven-seg/VGA), and winner indication.

---
 rtl/match_pkg.sv | 27 ++
 rtl/frame_tick_sync.sv | 28 ++
 rtl/match_controller.sv | 184 ++++++++++++++++++
 tb/tb_match_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared match-state encoding for the match sequencer, VGA overlay and seven-seg path.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } match_state_e;

  localparam logic [2:0] MATCH_ENC_IDLE  = 3'd0;
  localparam logic [2:0] MATCH_ENC_SERVE = 3'd1;
  localparam logic [2:0] MATCH_ENC_PLAY  = 3'd2;
  localparam logic [2:0] MATCH_ENC_POINT = 3'd3;
  localparam logic [2:0] MATCH_ENC_OVER  = 3'd4;

  // Index/counter widths never collapse to zero bits, even for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings vsync into the clkin domain and emits a one-cycle tick per frame.
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_tick
);

  logic r_s1, r_s2, r_s3, r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      // Registered edge pulse keeps the tick glitch-free for the FSM.
      r_tick <= r_s2 & ~r_s3;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/match_controller.sv
// N-player match sequencer: serve/point countdowns, score array and win detection.
// Optional MATCH_WIN_BY_TWO_EN: win needs a 2-point lead; saturation forces a win.
module match_controller
  import match_pkg::*;
#(
  parameter int  NUM_PLAYERS  = 2,
  parameter int  SCORE_W      = 8,
  parameter int  WIN_SCORE    = 11,
  parameter int  SERVE_FRAMES = 60,
  parameter int  POINT_FRAMES = 90,
  localparam int IDX_W        = clog2_min1(NUM_PLAYERS)
) (
  input  logic                           clkin,
  input  logic                           rst,
  input  logic                           vsync,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           point_valid,
  input  logic [IDX_W-1:0]               point_idx,
  output logic [2:0]                     state,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [IDX_W-1:0]               serve_idx,
  output logic                           ball_enable,
  output logic                           point_ack,
  output logic                           winner_valid,
  output logic [IDX_W-1:0]               winner_idx
);

  localparam int CNT_W = clog2_min1(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [IDX_W:0]     NP_EXT     = (IDX_W+1)'(NUM_PLAYERS);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_PLAYERS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

  match_state_e       r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score [NUM_PLAYERS];
  logic [IDX_W-1:0]   r_serve_idx;
  logic [IDX_W-1:0]   r_winner_idx;
  logic               r_ball_en;
  logic               r_point_ack;
  logic               r_winner_valid;
  logic               r_start_d;

  logic               w_tick;
  logic               w_start_rise;
  logic               w_point_ok;
  logic               w_win;
  logic [SCORE_W-1:0] w_cur_score;
  logic [SCORE_W-1:0] w_new_score;

  frame_tick_sync u_frame_tick_sync (
    .clk     (clkin),
    .rst     (rst),
    .i_async (vsync),
    .o_tick  (w_tick)
  );

  assign w_start_rise = start & ~r_start_d;
  assign w_point_ok   = point_valid & ~pause & ({1'b0, point_idx} < NP_EXT);

  always_comb begin
    w_cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (point_idx == IDX_W'(i)) w_cur_score = r_score[i];
    end
  end

  assign w_new_score = (w_cur_score == SCORE_MAX) ? SCORE_MAX : (w_cur_score + SCORE_ONE);

`ifdef MATCH_WIN_BY_TWO_EN
  localparam logic [SCORE_W+1:0] LEAD = (SCORE_W+2)'(2);
  logic w_lead_ok;

  always_comb begin
    w_lead_ok = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if ((point_idx != IDX_W'(i)) &&
          (({2'b00, r_score[i]} + LEAD) > {2'b00, w_new_score}))
        w_lead_ok = 1'b0;
    end
    // A saturated counter can no longer grow its lead, so it wins outright.
    w_win = (w_new_score == SCORE_MAX) | ((w_new_score >= WIN_VAL) & w_lead_ok);
  end
`else
  assign w_win = (w_new_score == WIN_VAL);
`endif

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_serve_idx    <= '0;
      r_winner_idx   <= '0;
      r_ball_en      <= 1'b0;
      r_point_ack    <= 1'b0;
      r_winner_valid <= 1'b0;
      r_start_d      <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
    end else begin
      r_start_d   <= start;
      r_point_ack <= 1'b0;
      r_ball_en   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_rise) begin
            for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
            r_serve_idx    <= '0;
            r_winner_valid <= 1'b0;
            r_winner_idx   <= '0;
            r_cnt          <= SERVE_LOAD;
            r_state        <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (!pause) begin
            if (r_cnt == '0) begin
              r_state   <= ST_PLAY;
              r_ball_en <= 1'b1;
            end else if (w_tick) begin
              r_cnt <= r_cnt - CNT_ONE;
              if (r_cnt == CNT_ONE) begin
                r_state   <= ST_PLAY;
                r_ball_en <= 1'b1;
              end
            end
          end
        end
        ST_PLAY: begin
          // Frame ticks carry no meaning here, so a coincident point always wins.
          r_ball_en <= ~pause & ~w_point_ok;
          if (w_point_ok) begin
            r_point_ack <= 1'b1;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (point_idx == IDX_W'(i)) r_score[i] <= w_new_score;
            end
            if (w_win) begin
              r_winner_idx   <= point_idx;
              r_winner_valid <= 1'b1;
              r_state        <= ST_OVER;
            end else begin
              r_serve_idx <= (r_serve_idx == LAST_IDX) ? '0 : (r_serve_idx + IDX_ONE);
              r_cnt       <= POINT_LOAD;
              r_state     <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          if (!pause) begin
            if (r_cnt == '0) begin
              r_cnt   <= SERVE_LOAD;
              r_state <= ST_SERVE;
            end else if (w_tick) begin
              if (r_cnt == CNT_ONE) begin
                r_cnt   <= SERVE_LOAD;
                r_state <= ST_SERVE;
              end else begin
                r_cnt <= r_cnt - CNT_ONE;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign scores[g*SCORE_W +: SCORE_W] = r_score[g];
  end

  assign state        = r_state;
  assign serve_idx    = r_serve_idx;
  assign ball_enable  = r_ball_en;
  assign point_ack    = r_point_ack;
  assign winner_valid = r_winner_valid;
  assign winner_idx   = r_winner_idx;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a per-cycle reference model.
module tb_match_controller;

  localparam int NP  = 3;
  localparam int SW  = 8;
  localparam int WS  = 3;
  localparam int SF  = 2;
  localparam int PF  = 3;
  localparam int SMAX = 255;

  logic        clkin = 1'b0;
  logic        rst = 1'b0;
  logic        vsync, start, pause, point_valid;
  logic [1:0]  point_idx;
  logic [2:0]  state;
  logic [23:0] scores;
  logic [1:0]  serve_idx, winner_idx;
  logic        ball_enable, point_ack, winner_valid;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  match_controller #(
    .NUM_PLAYERS (NP),
    .SCORE_W     (SW),
    .WIN_SCORE   (WS),
    .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .vsync       (vsync),
    .start       (start),
    .pause       (pause),
    .point_valid (point_valid),
    .point_idx   (point_idx),
    .state       (state),
    .scores      (scores),
    .serve_idx   (serve_idx),
    .ball_enable (ball_enable),
    .point_ack   (point_ack),
    .winner_valid(winner_valid),
    .winner_idx  (winner_idx)
  );

  always #5 clkin = ~clkin;

  // Reference model: match rules evaluated once per clock edge.
  int m_state, m_cnt, m_serve, m_wi;
  int m_score [NP];
  bit m_ball, m_ack, m_wv, m_prev_start;
  bit vs_hist [1:4];

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_serve = 0; m_wi = 0;
    m_ball = 0; m_ack = 0; m_wv = 0; m_prev_start = 0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
    for (int k = 1; k <= 4; k++) vs_hist[k] = 0;
  endtask

  function automatic bit model_win(int p, int s);
`ifdef MATCH_WIN_BY_TWO_EN
    bit lead = 1;
    for (int j = 0; j < NP; j++) if (j != p && s < m_score[j] + 2) lead = 0;
    return (s == SMAX) || (s >= WS && lead);
`else
    return s == WS;
`endif
  endfunction

  task automatic model_step();
    bit tick, srise;
    int p, s;
    tick = vs_hist[3] && !vs_hist[4];
    vs_hist[4] = vs_hist[3]; vs_hist[3] = vs_hist[2];
    vs_hist[2] = vs_hist[1]; vs_hist[1] = vsync;
    srise = start && !m_prev_start;
    m_prev_start = start;
    m_ack = 0;
    p = int'(point_idx);
    case (m_state)
      0, 4: if (srise) begin
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_serve = 0; m_wv = 0; m_wi = 0; m_cnt = SF; m_state = 1;
      end
      1: if (!pause) begin
        if (m_cnt == 0) m_state = 2;
        else if (tick) begin
          m_cnt--;
          if (m_cnt == 0) m_state = 2;
        end
      end
      2: if (point_valid && !pause && p < NP) begin
        s = (m_score[p] + 1 > SMAX) ? SMAX : m_score[p] + 1;
        m_score[p] = s;
        m_ack = 1;
        if (model_win(p, s)) begin
          m_wv = 1; m_wi = p; m_state = 4;
        end else begin
          m_serve = (m_serve + 1) % NP; m_cnt = PF; m_state = 3;
        end
      end
      3: if (!pause) begin
        if (m_cnt == 0) begin m_state = 1; m_cnt = SF; end
        else if (tick) begin
          m_cnt--;
          if (m_cnt == 0) begin m_state = 1; m_cnt = SF; end
        end
      end
      default: m_state = 0;
    endcase
    m_ball = (m_state == 2) && !pause;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clkin or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  function automatic logic [63:0] dut_vec();
    return 64'({state, scores, serve_idx, ball_enable, point_ack, winner_valid,
                (winner_valid ? winner_idx : 2'd0)});
  endfunction

  function automatic logic [63:0] model_vec();
    logic [23:0] sc;
    for (int i = 0; i < NP; i++) sc[i*8 +: 8] = 8'(m_score[i]);
    return 64'({3'(m_state), sc, 2'(m_serve), m_ball, m_ack, m_wv,
                (m_wv ? 2'(m_wi) : 2'd0)});
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clkin);
      #2;
      if (cmp_en) chk("model_cycle", dut_vec(), model_vec());
    end
  end

  task automatic frames(int n);
    repeat (n) begin
      @(negedge clkin); vsync = 1'b1;
      repeat (2) @(negedge clkin);
      vsync = 1'b0;
      repeat (4) @(negedge clkin);
    end
  endtask

  task automatic press_start();
    @(negedge clkin); start = 1'b1;
    @(negedge clkin); start = 1'b0;
  endtask

  task automatic point(int idx);
    @(negedge clkin); point_valid = 1'b1; point_idx = 2'(idx);
    @(negedge clkin); point_valid = 1'b0;
  endtask

  initial begin
    vsync = 0; start = 0; pause = 0; point_valid = 0; point_idx = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clkin);
    cmp_en = 1'b1;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_scores", 64'(scores), 64'd0);
    chk("reset_flags", 64'({ball_enable, point_ack, winner_valid, serve_idx}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clkin);
    chk("idle_hold", 64'(state), 64'd0);

    press_start();
    chk("start_serve", 64'(state), 64'd1);
    frames(1);
    chk("serve_one_tick", 64'(state), 64'd1);
    frames(1);
    chk("play_state", 64'(state), 64'd2);
    chk("play_ball", 64'(ball_enable), 64'd1);
    chk("play_scores0", 64'(scores), 64'd0);

    point(1);
    chk("p1_ack", 64'(point_ack), 64'd1);
    chk("p1_scores", 64'(scores), 64'h000100);
    chk("p1_serve", 64'(serve_idx), 64'd1);
    chk("p1_state", 64'(state), 64'd3);
    @(negedge clkin);
    chk("p1_ack_drop", 64'(point_ack), 64'd0);
    frames(2);
    chk("point_2ticks", 64'(state), 64'd3);
    frames(1);
    chk("point_to_serve", 64'(state), 64'd1);
    frames(2);
    chk("serve_to_play", 64'(state), 64'd2);

    point(3);
    chk("bad_idx_ack", 64'(point_ack), 64'd0);
    chk("bad_idx_scores", 64'({state, scores}), 64'({3'd2, 24'h000100}));
    point(0);
    frames(3);
    point(0);
    chk("serve_pt_ack", 64'(point_ack), 64'd0);
    chk("serve_pt_scores", 64'({state, scores}), 64'({3'd1, 24'h000101}));
    frames(2);

    @(negedge clkin); pause = 1'b1;
    @(negedge clkin);
    chk("pause_ball", 64'(ball_enable), 64'd0);
    point(2);
    chk("pause_pt", 64'({point_ack, state, scores}), 64'({1'b0, 3'd2, 24'h000101}));
    @(negedge clkin); pause = 1'b0;
    @(negedge clkin);
    chk("unpause_ball", 64'(ball_enable), 64'd1);

    point(2);
    chk("serve_wrap", 64'(serve_idx), 64'd0);
    @(negedge clkin); pause = 1'b1;
    frames(5);
    chk("pause_point_hold", 64'(state), 64'd3);
    @(negedge clkin); pause = 1'b0;
    frames(2);
    chk("point_resume", 64'(state), 64'd3);
    frames(1);
    chk("point_resume_done", 64'(state), 64'd1);
    frames(2);
    point(2);
    frames(5);
    point(2);
    chk("win_state", 64'(state), 64'd4);
    chk("win_flags", 64'({winner_valid, winner_idx, ball_enable, point_ack}),
        64'({1'b1, 2'd2, 1'b0, 1'b1}));
    chk("win_scores", 64'(scores), 64'h030101);
    frames(2);
    point(1);
    chk("over_hold", 64'({state, scores, point_ack}), 64'({3'd4, 24'h030101, 1'b0}));

    press_start();
    chk("restart", 64'({state, scores, winner_valid, serve_idx}), 64'({3'd1, 24'h0, 1'b0, 2'd0}));

    frames(2);
    point(0); frames(5);
    point(1); frames(5);
    point(0); frames(5);
    point(1); frames(5);
    chk("tie_2_2", 64'({state, scores, serve_idx}), 64'({3'd2, 24'h000202, 2'd1}));
    point(0);
`ifdef MATCH_WIN_BY_TWO_EN
    chk("lead1_nowin", 64'({state, winner_valid, scores}), 64'({3'd3, 1'b0, 24'h000203}));
    frames(5);
    point(0);
    chk("lead2_win", 64'({state, winner_valid, winner_idx, scores}),
        64'({3'd4, 1'b1, 2'd0, 24'h000204}));
`else
    chk("exact_win", 64'({state, winner_valid, winner_idx, scores}),
        64'({3'd4, 1'b1, 2'd0, 24'h000203}));
`endif

    press_start();
    frames(2);
    point(1);
    frames(1);
    chk("mid_point", 64'(state), 64'd3);
    @(negedge clkin);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_state", 64'(state), 64'd0);
    chk("async_rst_out", 64'({scores, serve_idx, ball_enable, point_ack, winner_valid}), 64'd0);
    @(negedge clkin); rst = 1'b0;
    repeat (3) @(negedge clkin);
    chk("post_rst_idle", 64'(state), 64'd0);
    press_start();
    chk("post_rst_start", 64'(state), 64'd1);
    repeat (2) @(negedge clkin);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
